// File: rtl/pcie_cdc_pkg.sv
// Shared types for the PCIe response CDC path: FIFO entry layout and field offsets.
package pcie_cdc_pkg;

  localparam int PCIE_DATA_W = 64;
  localparam int PCIE_STRB_W = PCIE_DATA_W / 8;
  localparam int PCIE_RESP_W = 73;
  localparam int LAST_BIT    = 72;
  localparam int STRB_LSB    = 64;

  typedef struct packed {
    logic                   last;
    logic [PCIE_STRB_W-1:0] strb;
    logic [PCIE_DATA_W-1:0] data;
  } pcie_resp_entry_t;

endpackage

// File: rtl/pcie_resp_skidbuf.sv
// Two-entry circular skid buffer; push and pop may occur on the same edge.
module pcie_resp_skidbuf
  import pcie_cdc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  pcie_resp_entry_t push_data,
  input  logic             pop,
  output pcie_resp_entry_t head,
  output logic [1:0]       count
);

  pcie_resp_entry_t mem [2];
  logic             head_ptr;
  logic             tail_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) tail_ptr <= ~tail_ptr;
      if (pop)  head_ptr <= ~head_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage is deliberately not reset; the consumer masks the
  // head entry whenever count is zero, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= push_data;
  end

  assign head = mem[head_ptr];

endmodule

// File: rtl/pcie_resp_cdc_reader.sv
// Pops the PCIe response CDC FIFO into a valid/ready beat stream, tracking packets
// and forcing a last flag on packets that run past MAX_BEATS.
module pcie_resp_cdc_reader
  import pcie_cdc_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  output logic                    o_rd,
  input  logic [DATA_W+DATA_W/8:0] i_rdata,
  input  logic                    i_rempty,
  output logic                    o_resp_valid,
  input  logic                    i_resp_ready,
  output logic [DATA_W-1:0]       o_resp_data,
  output logic [DATA_W/8-1:0]     o_resp_strb,
  output logic                    o_resp_last,
  output logic                    o_overrun,
  output logic [CNT_W-1:0]        o_pkt_cnt
);

  localparam int                BEAT_W   = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BEATS - 1);

  pcie_resp_entry_t  head;
  logic [1:0]        count;
  logic              rd_pend;
  logic [2:0]        occ;
  logic              pop;
  logic              forced;
  logic [BEAT_W-1:0] beat_cnt;

  pcie_resp_skidbuf u_skidbuf (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (rd_pend),
    .push_data (pcie_resp_entry_t'(i_rdata)),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign o_resp_valid = (count != 2'd0);
  assign pop          = o_resp_valid && i_resp_ready;

  // A read already in flight owns a buffer slot, so credit counts it too.
  assign occ  = {1'b0, count} + {2'b00, rd_pend};
  assign o_rd = !i_rst && !i_rempty && ((occ < 3'd2) || ((occ == 3'd2) && pop));

  assign forced      = o_resp_valid && (beat_cnt == BEAT_MAX) && !head.last;
  assign o_resp_last = o_resp_valid && (head.last || forced);
  assign o_resp_data = o_resp_valid ? head.data : '0;
  assign o_resp_strb = o_resp_valid ? head.strb : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_pend   <= 1'b0;
      beat_cnt  <= '0;
      o_overrun <= 1'b0;
      o_pkt_cnt <= '0;
    end else begin
      rd_pend <= o_rd;
      if (pop) begin
        if (o_resp_last) begin
          beat_cnt  <= '0;
          o_pkt_cnt <= o_pkt_cnt + 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
        if (forced) o_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pcie_resp_cdc_reader.sv
// Randomised bench: a queue-based FIFO model feeds the reader and a packet-level
// model predicts every beat, last flag, packet count and overrun flag.
module tb_pcie_resp_cdc_reader;
  import pcie_cdc_pkg::*;

  localparam int MAX_BEATS = 16;
  localparam int CNT_W     = 4;

  logic             i_clk;
  logic             i_rst;
  logic             o_rd;
  logic [72:0]      i_rdata;
  logic             i_rempty;
  logic             o_resp_valid;
  logic             i_resp_ready;
  logic [63:0]      o_resp_data;
  logic [7:0]       o_resp_strb;
  logic             o_resp_last;
  logic             o_overrun;
  logic [CNT_W-1:0] o_pkt_cnt;

  pcie_resp_cdc_reader #(.DATA_W(64), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .o_rd         (o_rd),
    .i_rdata      (i_rdata),
    .i_rempty     (i_rempty),
    .o_resp_valid (o_resp_valid),
    .i_resp_ready (i_resp_ready),
    .o_resp_data  (o_resp_data),
    .o_resp_strb  (o_resp_strb),
    .o_resp_last  (o_resp_last),
    .o_overrun    (o_overrun),
    .o_pkt_cnt    (o_pkt_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [72:0] fifo_q [$];
  logic [72:0] exp_q  [$];
  int          last_q [$];
  int passed, total;
  int cycle, beats_out, words_pushed, rd_pulses;
  int first_rd_cycle, first_valid_cycle, last_valid_cycle, valid_cycles;
  int m_beats, m_pkt;
  bit m_ovr;
  logic rd_now;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
  endtask

  function automatic logic [72:0] mk(input bit last);
    return {last, 8'($urandom), $urandom, $urandom};
  endfunction

  task automatic push(input logic [72:0] w);
    fifo_q.push_back(w);
    words_pushed++;
    i_rempty = 1'b0;
  endtask

  // Per-cycle comparison against the packet model, sampled mid-cycle.
  task automatic compare_cycle();
    logic [72:0] w;
    bit          exp_last;
    check("rd_while_empty", 64'(o_rd && i_rempty), 64'd0);
    check("pkt_cnt", 64'(o_pkt_cnt), 64'(m_pkt));
    check("overrun", 64'(o_overrun), 64'(m_ovr));
    if (o_resp_valid) begin
      valid_cycles++;
      last_valid_cycle = cycle;
      if (first_valid_cycle < 0) first_valid_cycle = cycle;
      if (exp_q.size() == 0) begin
        check("spurious_beat", 64'd1, 64'd0);
      end else begin
        w        = exp_q[0];
        exp_last = w[LAST_BIT] || (m_beats == MAX_BEATS - 1);
        check("beat_data", o_resp_data, w[63:0]);
        check("beat_strb", 64'(o_resp_strb), 64'(w[71:64]));
        check("beat_last", 64'(o_resp_last), 64'(exp_last));
        if (i_resp_ready) begin
          void'(exp_q.pop_front());
          if (exp_last) begin
            last_q.push_back(beats_out);
            m_beats = 0;
            m_pkt   = (m_pkt + 1) % (1 << CNT_W);
            if (!w[LAST_BIT]) m_ovr = 1'b1;
          end else begin
            m_beats++;
          end
          beats_out++;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    rd_now = o_rd;
    if (!i_rst) begin
      if (rd_now) begin
        rd_pulses++;
        if (first_rd_cycle < 0) first_rd_cycle = cycle;
      end
      compare_cycle();
    end
    @(posedge i_clk);
    #1;
    cycle++;
    if (rd_now && !i_rst && fifo_q.size() != 0) begin
      i_rdata = fifo_q.pop_front();
      exp_q.push_back(i_rdata);
    end
    i_rempty = (fifo_q.size() == 0);
  endtask

  task automatic apply_reset();
    i_rst        = 1'b1;
    i_resp_ready = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    last_q.delete();
    i_rempty          = 1'b1;
    i_rdata           = '0;
    m_beats           = 0;
    m_pkt             = 0;
    m_ovr             = 1'b0;
    beats_out         = 0;
    words_pushed      = 0;
    rd_pulses         = 0;
    first_rd_cycle    = -1;
    first_valid_cycle = -1;
    last_valid_cycle  = -1;
    valid_cycles      = 0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
  endtask

  task automatic clear_marks();
    last_q.delete();
    rd_pulses         = 0;
    first_rd_cycle    = -1;
    first_valid_cycle = -1;
    last_valid_cycle  = -1;
    valid_cycles      = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    i_resp_ready = 1'b1;
    while (beats_out < words_pushed && n < 400) begin
      tick();
      n++;
    end
    check("drain_complete", 64'(beats_out), 64'(words_pushed));
    tick();
    tick();
    check("idle_after_drain", 64'(o_resp_valid), 64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    passed = 0;
    total  = 0;
    cycle  = 0;
    i_resp_ready = 1'b0;
    i_rempty     = 1'b1;
    i_rdata      = '0;
    i_rst        = 1'b1;
    #1;
    check("reset_valid", 64'(o_resp_valid), 64'd0);
    check("reset_rd", 64'(o_rd), 64'd0);
    check("reset_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
    check("reset_overrun", 64'(o_overrun), 64'd0);
    apply_reset();

    // Burst with ready high: 4 words, last on the fourth.
    i_resp_ready = 1'b1;
    push(mk(0)); push(mk(0)); push(mk(0)); push(mk(1));
    drain();
    check("burst_latency", 64'(first_valid_cycle - first_rd_cycle), 64'd2);
    check("burst_valid_cycles", 64'(valid_cycles), 64'd4);
    check("burst_consecutive", 64'(last_valid_cycle - first_valid_cycle), 64'd3);
    check("burst_last_idx", 64'(last_q.size() == 1 ? last_q[0] : -1), 64'd3);
    check("burst_pkt_cnt", 64'(o_pkt_cnt), 64'd1);

    // Backpressure: 6 words, ready low for 5 cycles.
    apply_reset();
    for (int i = 0; i < 6; i++) push(mk(i == 5));
    repeat (5) tick();
    check("bp_rd_pulses", 64'(rd_pulses), 64'd2);
    check("bp_rd_low", 64'(o_rd), 64'd0);
    check("bp_valid_held", 64'(o_resp_valid), 64'd1);
    drain();
    check("bp_beats_out", 64'(beats_out), 64'd6);
    check("bp_pkt_cnt", 64'(o_pkt_cnt), 64'd1);

    // Ready toggling every cycle while the FIFO stays non-empty.
    apply_reset();
    for (int i = 0; i < 4; i++) push(mk($urandom_range(0, 3) == 0));
    for (int i = 0; i < 40; i++) begin
      i_resp_ready = i[0];
      if (!i[0]) push(mk($urandom_range(0, 3) == 0));
      tick();
    end
    drain();

    // Overrun: 20 words with no last, then one closing word.
    apply_reset();
    i_resp_ready = 1'b1;
    for (int i = 0; i < 20; i++) push(mk(0));
    drain();
    check("ovr_forced_idx", 64'(last_q.size() == 1 ? last_q[0] : -1), 64'd15);
    check("ovr_flag", 64'(o_overrun), 64'd1);
    check("ovr_pkt_cnt", 64'(o_pkt_cnt), 64'd1);
    push(mk(1));
    drain();
    check("ovr_next_last_idx", 64'(last_q.size() == 2 ? last_q[1] : -1), 64'd20);
    check("ovr_next_pkt_cnt", 64'(o_pkt_cnt), 64'd2);

    // Reset while a read strobe is active and a beat is held.
    i_resp_ready = 1'b0;
    push(mk(1));
    repeat (3) tick();
    push(mk(1));
    @(negedge i_clk);
    check("mid_rd_before", 64'(o_rd), 64'd1);
    check("mid_valid_before", 64'(o_resp_valid), 64'd1);
    i_rst = 1'b1;
    #1;
    check("mid_rst_rd", 64'(o_rd), 64'd0);
    check("mid_rst_valid", 64'(o_resp_valid), 64'd0);
    check("mid_rst_data", o_resp_data, 64'd0);
    check("mid_rst_strb", 64'(o_resp_strb), 64'd0);
    check("mid_rst_last", 64'(o_resp_last), 64'd0);
    check("mid_rst_overrun", 64'(o_overrun), 64'd0);
    check("mid_rst_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
    apply_reset();
    i_resp_ready = 1'b1;
    repeat (6) tick();
    check("mid_no_beat", 64'(valid_cycles), 64'd0);
    check("mid_no_rd", 64'(rd_pulses), 64'd0);

    // Counter wrap with a 4-bit packet counter: 17 single-beat packets.
    apply_reset();
    for (int i = 0; i < 17; i++) push(mk(1));
    drain();
    check("wrap_pkt_cnt", 64'(o_pkt_cnt), 64'd1);
    check("wrap_lasts", 64'(last_q.size()), 64'd17);

    // Random traffic and backpressure.
    apply_reset();
    clear_marks();
    for (int i = 0; i < 400; i++) begin
      i_resp_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 4) push(mk($urandom_range(0, 4) == 0));
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
